// File: rtl/eth_chdr_deframer.sv
// Strips the pad/Ethernet/IPv4/UDP header from CHDR-over-UDP frames.
// Frames addressed to this node pass through with zero latency and carry a
// route tag on e2x_tuser; all other frames are consumed and counted.
module eth_chdr_deframer #(
  parameter int CHDR_W = 64,
  parameter int VAL_W  = 112
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [47:0]       my_mac,
  input  logic [31:0]       my_ip,
  input  logic [15:0]       my_port,
  input  logic [CHDR_W-1:0] eth_tdata,
  input  logic              eth_tvalid,
  input  logic              eth_tlast,
  output logic              eth_tready,
  output logic [CHDR_W-1:0] e2x_tdata,
  output logic [VAL_W-1:0]  e2x_tuser,
  output logic              e2x_tvalid,
  output logic              e2x_tlast,
  input  logic              e2x_tready,
  output logic [31:0]       good_cnt,
  output logic [31:0]       drop_cnt
);

  localparam int unsigned CNT_W   = 3;
  localparam logic [CNT_W-1:0] LAST_HDR = 3'd5;

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             load_user, inc_good, inc_drop;

  logic [47:0] dst_mac, src_mac;
  logic [15:0] ethertype;
  logic [7:0]  ver_ihl, protocol;
  logic [13:0] frag;
  logic [31:0] src_ip, dst_ip;
  logic        hdr_ok;

  // Address/protocol filter evaluated against word 5 plus captured fields
  assign hdr_ok = ((dst_mac == my_mac) || (dst_mac == {48{1'b1}})) &&
                  (ethertype == 16'h0800) && (ver_ihl == 8'h45) &&
                  (frag == 14'd0) && (protocol == 8'd17) &&
                  (dst_ip == my_ip) && (eth_tdata[47:32] == my_port);

  // Payload path is a straight wire; qualified by e2x_tvalid
  assign e2x_tdata = eth_tdata;

  // State and header word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HDR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state, handshake outputs and bookkeeping strobes
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    eth_tready = 1'b1;
    e2x_tvalid = 1'b0;
    e2x_tlast  = 1'b0;
    load_user  = 1'b0;
    inc_good   = 1'b0;
    inc_drop   = 1'b0;
    case (state)
      ST_HDR: begin
        if (eth_tvalid) begin
          if (eth_tlast) begin
            cnt_nx   = '0;
            inc_drop = 1'b1;
          end else if (cnt == LAST_HDR) begin
            cnt_nx = '0;
            if (hdr_ok) begin
              state_nx  = ST_PASS;
              load_user = 1'b1;
            end else begin
              state_nx = ST_DROP;
              inc_drop = 1'b1;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      ST_PASS: begin
        eth_tready = e2x_tready;
        e2x_tvalid = eth_tvalid;
        e2x_tlast  = eth_tlast;
        if (eth_tvalid && e2x_tready && eth_tlast) begin
          state_nx = ST_HDR;
          inc_good = 1'b1;
        end
      end
      ST_DROP: begin
        if (eth_tvalid && eth_tlast) begin
          state_nx = ST_HDR;
        end
      end
      default: begin
        state_nx = ST_HDR;
        cnt_nx   = '0;
      end
    endcase
  end

  // Header field capture, one slice per header word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_mac   <= '0;
      src_mac   <= '0;
      ethertype <= '0;
      ver_ihl   <= '0;
      frag      <= '0;
      protocol  <= '0;
      src_ip    <= '0;
      dst_ip    <= '0;
    end else if (state == ST_HDR && eth_tvalid) begin
      case (cnt)
        3'd0: dst_mac[47:32] <= eth_tdata[15:0];
        3'd1: begin
          dst_mac[31:0]  <= eth_tdata[63:32];
          src_mac[47:16] <= eth_tdata[31:0];
        end
        3'd2: begin
          src_mac[15:0] <= eth_tdata[63:48];
          ethertype     <= eth_tdata[47:32];
          ver_ihl       <= eth_tdata[31:24];
        end
        3'd3: begin
          frag     <= eth_tdata[45:32];
          protocol <= eth_tdata[23:16];
        end
        3'd4: begin
          src_ip <= eth_tdata[63:32];
          dst_ip <= eth_tdata[31:0];
        end
        default: ;
      endcase
    end
  end

  // Route tag and frame counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e2x_tuser <= '0;
      good_cnt  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (load_user) begin
        e2x_tuser <= VAL_W'({src_mac, src_ip, eth_tdata[63:48], eth_tdata[47:32]});
      end
      if (inc_good) good_cnt <= good_cnt + 32'd1;
      if (inc_drop) drop_cnt <= drop_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_eth_chdr_deframer.sv
// Directed bench for eth_chdr_deframer.
module tb_eth_chdr_deframer;

  localparam logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [31:0] MY_IP   = 32'hC0A8_0A02;
  localparam logic [15:0] MY_PORT = 16'd49153;
  localparam logic [47:0] SRC_MAC = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [31:0] SRC_IP  = 32'hC0A8_0A01;
  localparam logic [15:0] SRC_PRT = 16'd5000;
  localparam logic [111:0] EXP_USER = {SRC_MAC, SRC_IP, SRC_PRT, MY_PORT};

  logic         clk = 1'b0;
  logic         rst;
  logic [47:0]  my_mac;
  logic [31:0]  my_ip;
  logic [15:0]  my_port;
  logic [63:0]  eth_tdata;
  logic         eth_tvalid, eth_tlast, eth_tready;
  logic [63:0]  e2x_tdata;
  logic [111:0] e2x_tuser;
  logic         e2x_tvalid, e2x_tlast, e2x_tready;
  logic [31:0]  good_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;
  int exp_good = 0;
  int exp_drop = 0;

  logic [63:0] frame [0:15];
  int          flen;

  logic [63:0]  mon_data [$];
  logic         mon_last [$];
  logic [111:0] mon_user [$];
  int           vld_seen = 0;

  always #5 clk = ~clk;

  eth_chdr_deframer #(.CHDR_W(64), .VAL_W(112)) dut (
    .clk(clk), .rst(rst), .my_mac(my_mac), .my_ip(my_ip), .my_port(my_port),
    .eth_tdata(eth_tdata), .eth_tvalid(eth_tvalid), .eth_tlast(eth_tlast),
    .eth_tready(eth_tready), .e2x_tdata(e2x_tdata), .e2x_tuser(e2x_tuser),
    .e2x_tvalid(e2x_tvalid), .e2x_tlast(e2x_tlast), .e2x_tready(e2x_tready),
    .good_cnt(good_cnt), .drop_cnt(drop_cnt)
  );

  // Output beat recorder; inputs are stable around the falling edge
  always @(negedge clk) begin
    if (!rst && e2x_tvalid) begin
      vld_seen++;
      if (e2x_tready) begin
        mon_data.push_back(e2x_tdata);
        mon_last.push_back(e2x_tlast);
        mon_user.push_back(e2x_tuser);
      end
    end
  end

  task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype,
                             input logic [15:0] dport, input int npay,
                             input logic [7:0] seed);
    frame[0] = {48'h0, dmac[47:32]};
    frame[1] = {dmac[31:0], SRC_MAC[47:16]};
    frame[2] = {SRC_MAC[15:0], etype, 8'h45, 8'h00, 16'd60};
    frame[3] = {16'h1234, 16'h4000, 8'h40, 8'd17, 16'hBEEF};
    frame[4] = {SRC_IP, MY_IP};
    frame[5] = {SRC_PRT, dport, 16'd40, 16'h0000};
    for (int i = 0; i < npay; i++) frame[6+i] = {seed, 24'hA5A5A5, 32'(i)};
    flen = 6 + npay;
  endtask

  task automatic send_frame(input bit tog, input bit mirror, input int nsend);
    bit acc;
    for (int i = 0; i < nsend; i++) begin
      eth_tdata  = frame[i];
      eth_tlast  = (i == flen - 1);
      eth_tvalid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 64 && !acc; c++) begin
        @(negedge clk);
        if (mirror && i >= 6) begin
          checks++;
          if (eth_tready !== e2x_tready) begin
            errors++;
            $display("FAIL ready_mirror word %0d: eth_tready=%b e2x_tready=%b", i, eth_tready, e2x_tready);
          end
        end
        acc = eth_tready;
        @(posedge clk); #1;
        if (tog) e2x_tready = ~e2x_tready;
      end
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL accept_timeout word %0d: not accepted, expected accept", i);
      end
    end
    eth_tvalid = 1'b0;
    eth_tlast  = 1'b0;
    e2x_tready = 1'b1;
    if (nsend == flen) begin
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (good_cnt !== 32'(exp_good)) begin
      errors++;
      $display("FAIL %s good_cnt: got %0d expected %0d", tag, good_cnt, exp_good);
    end
    checks++;
    if (drop_cnt !== 32'(exp_drop)) begin
      errors++;
      $display("FAIL %s drop_cnt: got %0d expected %0d", tag, drop_cnt, exp_drop);
    end
  endtask

  task automatic check_out(input string tag, input int start, input int npay);
    checks++;
    if (mon_data.size() !== start + npay) begin
      errors++;
      $display("FAIL %s beats: got %0d expected %0d", tag, mon_data.size() - start, npay);
    end else begin
      for (int i = 0; i < npay; i++) begin
        checks++;
        if (mon_data[start+i] !== frame[6+i] || mon_last[start+i] !== (i == npay - 1) ||
            mon_user[start+i] !== EXP_USER) begin
          errors++;
          $display("FAIL %s beat %0d: got data=%h last=%b user=%h expected data=%h last=%b user=%h",
                   tag, i, mon_data[start+i], mon_last[start+i], mon_user[start+i],
                   frame[6+i], (i == npay - 1), EXP_USER);
        end
      end
    end
  endtask

  task automatic pass_frame(input string tag, input logic [47:0] dmac, input bit tog,
                            input logic [7:0] seed);
    int start;
    start = mon_data.size();
    build_frame(dmac, 16'h0800, MY_PORT, 4, seed);
    send_frame(tog, tog, flen);
    exp_good++;
    check_out(tag, start, 4);
    check_counts(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    my_mac = MY_MAC; my_ip = MY_IP; my_port = MY_PORT;
    eth_tdata = '0; eth_tvalid = 1'b0; eth_tlast = 1'b0; e2x_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (eth_tready !== 1'b1 || e2x_tvalid !== 1'b0 || e2x_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got rdy=%b vld=%b last=%b expected 1 0 0", eth_tready, e2x_tvalid, e2x_tlast);
    end
    checks++;
    if (e2x_tuser !== 112'd0) begin
      errors++;
      $display("FAIL reset_tuser: got %h expected 0", e2x_tuser);
    end
    check_counts("reset");
    @(posedge clk); #1;
  endtask

  task automatic test_valid_frame();
    pass_frame("valid", MY_MAC, 1'b0, 8'h11);
  endtask

  task automatic test_drop(input string tag, input logic [15:0] etype, input logic [15:0] dport);
    int vs, start;
    vs = vld_seen;
    start = mon_data.size();
    build_frame(MY_MAC, etype, dport, 3, 8'h22);
    send_frame(1'b0, 1'b0, flen);
    exp_drop++;
    checks++;
    if (vld_seen !== vs || mon_data.size() !== start) begin
      errors++;
      $display("FAIL %s no_output: got %0d valid cycles expected 0", tag, vld_seen - vs);
    end
    check_counts(tag);
    pass_frame({tag, "_next"}, MY_MAC, 1'b0, 8'h33);
  endtask

  task automatic test_short_frame(input string tag, input int last_word);
    int vs;
    vs = vld_seen;
    build_frame(MY_MAC, 16'h0800, MY_PORT, 0, 8'h00);
    flen = last_word + 1;
    send_frame(1'b0, 1'b0, flen);
    exp_drop++;
    checks++;
    if (vld_seen !== vs) begin
      errors++;
      $display("FAIL %s no_output: got %0d valid cycles expected 0", tag, vld_seen - vs);
    end
    check_counts(tag);
    pass_frame({tag, "_next"}, MY_MAC, 1'b0, 8'h44);
  endtask

  task automatic test_broadcast();
    pass_frame("broadcast", 48'hFFFF_FFFF_FFFF, 1'b0, 8'h55);
  endtask

  task automatic test_backpressure();
    pass_frame("backpressure", MY_MAC, 1'b1, 8'h66);
  endtask

  task automatic test_reset_mid_payload();
    build_frame(MY_MAC, 16'h0800, MY_PORT, 4, 8'h77);
    send_frame(1'b0, 1'b0, 8);
    eth_tdata  = frame[8];
    eth_tvalid = 1'b1;
    #2;
    checks++;
    if (e2x_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre_valid: got %b expected 1", e2x_tvalid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (e2x_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_valid: got %b expected 0", e2x_tvalid);
    end
    exp_good = 0;
    exp_drop = 0;
    check_counts("midrst");
    eth_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    pass_frame("after_rst", MY_MAC, 1'b0, 8'h88);
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_drop("ethertype", 16'h86DD, MY_PORT);
    test_drop("dst_port", 16'h0800, 16'd49154);
    test_short_frame("tlast_w3", 3);
    test_short_frame("tlast_w5", 5);
    test_broadcast();
    test_backpressure();
    test_reset_mid_payload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
